// File: rtl/ascii_sched_pkg.sv
// ascii_sched_pkg: shared types and constants for the character-buffer write
// scheduler.
//   sched_state_t  - scheduler FSM states (IDLE, WRITE, CLEAR)
//   cursor_cmd_t   - commands the scheduler issues to the cursor tracker
//   ASCII_*        - control characters the scheduler decodes
//   DEFAULT_*      - default screen geometry
//   is_printable() - true for any character that lands in the RAM verbatim
package ascii_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } sched_state_t;

  typedef enum logic [2:0] {
    CUR_HOLD      = 3'd0,
    CUR_ADVANCE   = 3'd1,
    CUR_NEWLINE   = 3'd2,
    CUR_BACKSPACE = 3'd3,
    CUR_ZERO      = 3'd4
  } cursor_cmd_t;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int DEFAULT_COLS   = 80;
  localparam int DEFAULT_ROWS   = 30;
  localparam int DEFAULT_ADDR_W = 12;

  localparam logic [11:0] WRITE_COUNT_MAX = 12'hFFF;

  // Anything that is not newline or backspace is stored as-is.
  function automatic logic is_printable(input logic [7:0] ch);
    return (ch != ASCII_NL) && (ch != ASCII_BS);
  endfunction

endpackage

// File: rtl/ascii_write_scheduler_cursor_tracker.sv
// cursor_tracker: holds the text cursor as (row, col) plus the linear cell
// address row*COLS+col, and applies advance / newline / backspace / zero
// commands with wrap at the end of the screen (no scrolling).
//   clk, reset   - clock, synchronous active-high reset
//   cmd          - command applied on the next rising edge
//   cursor_addr  - current cursor cell address (registered)
module cursor_tracker
  import ascii_sched_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  cursor_cmd_t       cmd,
  output logic [ADDR_W-1:0] cursor_addr
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  logic [COL_W-1:0]  col_r,  col_nxt_s;
  logic [ROW_W-1:0]  row_r,  row_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;

  // Next-cursor arithmetic; row/col are kept alongside the address so a
  // newline can jump to the next row start without a divider.
  always_comb begin
    col_nxt_s  = col_r;
    row_nxt_s  = row_r;
    addr_nxt_s = addr_r;
    case (cmd)
      CUR_ADVANCE: begin
        if (addr_r == LAST_ADDR) begin
          col_nxt_s  = '0;
          row_nxt_s  = '0;
          addr_nxt_s = '0;
        end else if (col_r == LAST_COL) begin
          col_nxt_s  = '0;
          row_nxt_s  = row_r + ROW_W'(1);
          addr_nxt_s = addr_r + ADDR_W'(1);
        end else begin
          col_nxt_s  = col_r + COL_W'(1);
          addr_nxt_s = addr_r + ADDR_W'(1);
        end
      end
      CUR_NEWLINE: begin
        col_nxt_s = '0;
        if (row_r == LAST_ROW) begin
          row_nxt_s  = '0;
          addr_nxt_s = '0;
        end else begin
          row_nxt_s  = row_r + ROW_W'(1);
          addr_nxt_s = addr_r - ADDR_W'(col_r) + COLS_A;
        end
      end
      CUR_BACKSPACE: begin
        // Backspace at cell 0 is a no-op; it never wraps backwards.
        if (addr_r == '0) begin
          addr_nxt_s = addr_r;
        end else if (col_r == '0) begin
          col_nxt_s  = LAST_COL;
          row_nxt_s  = row_r - ROW_W'(1);
          addr_nxt_s = addr_r - ADDR_W'(1);
        end else begin
          col_nxt_s  = col_r - COL_W'(1);
          addr_nxt_s = addr_r - ADDR_W'(1);
        end
      end
      CUR_ZERO: begin
        col_nxt_s  = '0;
        row_nxt_s  = '0;
        addr_nxt_s = '0;
      end
      default: begin
        addr_nxt_s = addr_r;
      end
    endcase
  end

  // Cursor state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r  <= '0;
      row_r  <= '0;
      addr_r <= '0;
    end else begin
      col_r  <= col_nxt_s;
      row_r  <= row_nxt_s;
      addr_r <= addr_nxt_s;
    end
  end

  assign cursor_addr = addr_r;

endmodule

// File: rtl/ascii_write_scheduler.sv
// ascii_write_scheduler: owns the single write port of the character RAM.
// Arbitrates between the test generator and the keyboard (round-robin on a
// tie), decodes printable / newline / backspace, and runs a full-screen clear.
//   clk, reset            - clock, synchronous active-high reset
//   gen_valid/ascii/ready - generator character handshake
//   kb_valid/ascii/ready  - keyboard character handshake
//   clear_req             - level request to blank the screen
//   ram_we/addr/wdata     - character RAM write port (registered)
//   cursor_addr           - current cursor cell
//   busy                  - high while in WRITE or CLEAR
//   write_count           - printable characters written (saturating)
module ascii_write_scheduler
  import ascii_sched_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_valid,
  input  logic [7:0]        gen_ascii,
  output logic              gen_ready,
  input  logic              kb_valid,
  input  logic [7:0]        kb_ascii,
  output logic              kb_ready,
  input  logic              clear_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic [11:0]       write_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  sched_state_t      state_r;
  logic              last_kb_r;      // 1: keyboard got the previous grant
  logic [7:0]        char_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [7:0]        ram_wdata_r;
  logic              busy_r;
  logic [11:0]       write_count_r;

  logic              grant_gen_s;
  logic              grant_kb_s;
  logic [7:0]        grant_char_s;
  cursor_cmd_t       cursor_cmd_s;
  logic [ADDR_W-1:0] cursor_addr_s;

  // Arbiter: only in IDLE and only when no clear is pending.
  always_comb begin
    grant_gen_s = 1'b0;
    grant_kb_s  = 1'b0;
    if ((state_r == IDLE) && !clear_req) begin
      if (gen_valid && kb_valid) begin
        grant_gen_s = last_kb_r;
        grant_kb_s  = !last_kb_r;
      end else begin
        grant_gen_s = gen_valid;
        grant_kb_s  = kb_valid;
      end
    end else begin
      grant_gen_s = 1'b0;
      grant_kb_s  = 1'b0;
    end
  end

  assign grant_char_s = grant_kb_s ? kb_ascii : gen_ascii;

  // Cursor command: the cursor moves at the end of the WRITE cycle and is
  // zeroed together with the last clear write.
  always_comb begin
    cursor_cmd_s = CUR_HOLD;
    case (state_r)
      WRITE: begin
        if (char_r == ASCII_NL) begin
          cursor_cmd_s = CUR_NEWLINE;
        end else if (char_r == ASCII_BS) begin
          cursor_cmd_s = CUR_BACKSPACE;
        end else begin
          cursor_cmd_s = CUR_ADVANCE;
        end
      end
      CLEAR: begin
        if (ram_addr_r == LAST_ADDR) begin
          cursor_cmd_s = CUR_ZERO;
        end else begin
          cursor_cmd_s = CUR_HOLD;
        end
      end
      default: begin
        cursor_cmd_s = CUR_HOLD;
      end
    endcase
  end

  // Scheduler FSM and registered RAM port; the RAM write for a character is
  // prepared at acceptance so it appears during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_kb_r     <= 1'b0;
      char_r        <= 8'h00;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= '0;
      ram_wdata_r   <= 8'h00;
      busy_r        <= 1'b0;
      write_count_r <= 12'h000;
    end else begin
      case (state_r)
        IDLE: begin
          ram_we_r <= 1'b0;
          if (clear_req) begin
            state_r     <= CLEAR;
            busy_r      <= 1'b1;
            ram_we_r    <= 1'b1;
            ram_addr_r  <= '0;
            ram_wdata_r <= ASCII_SPACE;
          end else if (grant_gen_s || grant_kb_s) begin
            state_r   <= WRITE;
            busy_r    <= 1'b1;
            char_r    <= grant_char_s;
            last_kb_r <= grant_kb_s;
            if (is_printable(grant_char_s)) begin
              ram_we_r    <= 1'b1;
              ram_addr_r  <= cursor_addr_s;
              ram_wdata_r <= grant_char_s;
            end else if ((grant_char_s == ASCII_BS) && (cursor_addr_s != '0)) begin
              ram_we_r    <= 1'b1;
              ram_addr_r  <= cursor_addr_s - ADDR_W'(1);
              ram_wdata_r <= ASCII_SPACE;
            end
          end
        end
        WRITE: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          ram_we_r <= 1'b0;
          if (is_printable(char_r) && (write_count_r != WRITE_COUNT_MAX)) begin
            write_count_r <= write_count_r + 12'd1;
          end
        end
        CLEAR: begin
          if (ram_addr_r == LAST_ADDR) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            ram_we_r      <= 1'b0;
            write_count_r <= 12'h000;
          end else begin
            ram_addr_r <= ram_addr_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  cursor_tracker #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cursor_cmd_s),
    .cursor_addr (cursor_addr_s)
  );

  assign gen_ready   = grant_gen_s;
  assign kb_ready    = grant_kb_s;
  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = ram_wdata_r;
  assign cursor_addr = cursor_addr_s;
  assign busy        = busy_r;
  assign write_count = write_count_r;

endmodule

// File: doc/ascii_write_scheduler.md
# ascii_write_scheduler

Write-port scheduler for the on-screen character buffer. Arbitrates character writes between the ASCII test generator and the keyboard decoder, tracks the text cursor, and runs a full-screen clear sequence. Drives the single write port of the character RAM read by the VGA text renderer.

## Interface
- COLS, default 80: characters per row
- ROWS, default 30: rows per screen
- ADDR_W, default 12: character RAM address width; COLS*ROWS ≤ 2^ADDR_W
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- gen_valid  in  1  generator has a character
- gen_ascii  in  8  generator character
- gen_ready  out  1  generator character accepted this cycle when gen_valid & gen_ready
- kb_valid  in  1  keyboard has a character
- kb_ascii  in  8  keyboard character
- kb_ready  out  1  keyboard character accepted when kb_valid & kb_ready
- clear_req  in  1  level request to blank the screen
- ram_we  out  1  character RAM write enable
- ram_addr  out  ADDR_W  character RAM write address
- ram_wdata  out  8  character RAM write data
- cursor_addr  out  ADDR_W  current cursor cell (row*COLS+col)
- busy  out  1  high in WRITE and CLEAR
- write_count  out  12  printable characters written since reset/clear

## Operation
- States: IDLE, WRITE, CLEAR.
- IDLE: clear_req has top priority -> CLEAR, no ready asserted. Else grant exactly one requester: if only one valid, grant it; if both, round-robin (grant the one not granted last). Granted ready is high combinationally in that cycle only; latch character, -> WRITE. Neither valid: stay.
- WRITE (one cycle), by latched character:
  - printable (0x20–0x7E and others not listed): ram_we=1, ram_addr=cursor, ram_wdata=char; cursor+1; write_count+1 (saturate 4095).
  - 0x0A newline: ram_we=0; cursor to column 0 of next row.
  - 0x08 backspace: if cursor>0, cursor-1 and write 0x20 at the new cursor; at 0, no write, cursor stays 0. write_count unchanged.
  - -> IDLE.
- Wrap: advancing past COLS*ROWS-1 (printable or newline on last row) -> cursor 0. No scrolling.
- CLEAR: ram_we=1, ram_wdata=0x20, ram_addr steps 0..COLS*ROWS-1 one per cycle; on last cell cursor=0, write_count=0, -> IDLE. clear_req ignored while in CLEAR; both readies low.
- ram_we low in IDLE.

## Timing
- Reset values: state IDLE, all outputs 0 (ram_we, ram_addr, ram_wdata, cursor_addr, busy, write_count, gen_ready, kb_ready); round-robin pointer = "gen last", so keyboard wins the first tie.
- Acceptance in cycle N -> ram_we in N+1 -> updated cursor_addr/write_count visible N+2; next grant earliest N+2. Throughput 1 char / 2 cycles.
- clear_req sampled in IDLE at N -> first clear write (addr 0) N+1, last (addr COLS*ROWS-1) N+COLS*ROWS, IDLE at N+COLS*ROWS+1. Default: 2400 write cycles.
- clear_req and valid in the same IDLE cycle: clear wins, no ready; characters remain pending.
- reset mid-WRITE or mid-CLEAR: abort next edge, all reset values; partial clear not resumed.
- valid dropped without handshake: no effect.

## Structure
- Package ascii_sched_pkg: state enum (IDLE, WRITE, CLEAR), ASCII_NL=8'h0A, ASCII_BS=8'h08, ASCII_SPACE=8'h20, default COLS/ROWS.
- Sub-module cursor_tracker: holds cursor, commands advance/newline/backspace/zero, COLS/ROWS wrap arithmetic; scheduler owns FSM, arbiter, RAM port.

## Test plan
- Reset, gen_valid=1 with 'A' (0x41) -> gen_ready at N, ram_we/addr 0/data 0x41 at N+1, cursor_addr=1, write_count=1 at N+2.
- gen and kb both valid continuously -> grants alternate kb, gen, kb, gen; ram_wdata follows.
- Cursor 79, send 0x0A -> no ram_we, cursor 80; cursor 2399 + 'x' -> write at 2399, cursor 0.
- Cursor 5, send 0x08 -> write 0x20 at 4, cursor 4; at cursor 0, 0x08 -> no write, cursor 0.
- clear_req with gen_valid -> 2400 writes of 0x20 at addrs 0..2399, readies low, busy high, then cursor 0, write_count 0, generator accepted next.
- reset at clear address 1000 -> all outputs 0 next cycle, IDLE, no further writes.
